aes_round_key_store: RTL

Word-serial round-key buffer for the AES-256 datapath. It sits directly downstream of key expansion: it captures the 60 expanded 32-bit words (w[0]..w[59]) as a valid/ready stream. It then serves any of the 15 round keys as a 128-bit word to the cipher round engine, with one-cycle read latency. A round key may be read as soon as its four words are stored, so the cipher can start before expansion finishes.

---
 rtl/aes_round_key_store.sv | 113 +++++++++++
 1 files changed

// File: rtl/aes_round_key_store.sv
// AES-256 round-key buffer: captures 60 expanded words as a stream and
// serves 128-bit round keys with one-cycle latency once their words land.
module aes_round_key_store (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         wr_valid,
  input  logic [31:0]  wr_word,
  output logic         wr_ready,
  output logic         load_done,
  output logic [5:0]   word_count,
  input  logic         rd_req,
  input  logic [3:0]   rd_round,
  output logic         rd_valid,
  output logic [127:0] rd_key,
  output logic         rd_err
);

  localparam int NUM_WORDS  = 60;
  localparam int NUM_ROUNDS = NUM_WORDS / 4;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    READY   = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic [31:0]    mem_q [NUM_WORDS];
  logic           rd_valid_q, rd_valid_d;
  logic           rd_err_q, rd_err_d;
  logic [127:0]   rd_key_q, rd_key_d;

  logic           wr_acc;
  logic           in_range;
  logic           elig;
  logic [6:0]     need;
  logic [5:0]     base;
  logic [127:0]   key_sel;

  assign wr_ready   = (state_q != READY);
  assign load_done  = (state_q == READY);
  assign word_count = cnt_q;
  assign rd_valid   = rd_valid_q;
  assign rd_err     = rd_err_q;
  assign rd_key     = rd_key_q;

  assign wr_acc = wr_valid && wr_ready && !clear;

  // Eligibility uses the pre-write count, at 7 bits so round 15 cannot wrap.
  assign need     = {1'b0, rd_round, 2'b00} + 7'd4;
  assign in_range = (rd_round <= 4'(NUM_ROUNDS - 1));
  assign elig     = in_range && ({1'b0, cnt_q} >= need);
  assign base     = elig ? {rd_round, 2'b00} : 6'd0;

  assign key_sel = {mem_q[base], mem_q[base + 6'd1],
                    mem_q[base + 6'd2], mem_q[base + 6'd3]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (wr_acc) cnt_d = cnt_q + 6'd1;
    unique case (state_q)
      EMPTY: begin
        if (wr_acc) state_d = FILLING;
      end
      FILLING: begin
        if (wr_acc && cnt_q == 6'(NUM_WORDS - 1)) state_d = READY;
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    if (clear) begin
      state_d = EMPTY;
      cnt_d   = 6'd0;
    end
  end

  always_comb begin
    rd_valid_d = rd_req && !clear && elig;
    rd_err_d   = rd_req && !clear && !elig;
    rd_key_d   = rd_key_q;
    if (clear)           rd_key_d = '0;
    else if (rd_valid_d) rd_key_d = key_sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      cnt_q      <= 6'd0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_key_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      rd_key_q   <= rd_key_d;
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[cnt_q] <= wr_word;
  end

endmodule
